// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with execute and load-return writes,
// bypassed combinational reads, and a per-register busy scoreboard.
`default_nettype none

module regfile_mp #(
  parameter  int XLEN    = 64,
  parameter  int NREGS   = 16,
  parameter  int NRD     = 2,
  parameter  int ZERO_R0 = 0,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr,
  input  logic [AW-1:0]       wrsel,
  input  logic [1:0]          wrsrc,
  input  logic [XLEN-1:0]     din,
  input  logic [XLEN-1:0]     retaddr,
  input  logic [XLEN-1:0]     imm,
  input  logic [XLEN-1:0]     aluout,
  input  logic [1:0]          width,
  input  logic                sext,
  input  logic                ldwr,
  input  logic [AW-1:0]       ldsel,
  input  logic [XLEN-1:0]     lddata,
  input  logic                issue,
  input  logic [AW-1:0]       issue_sel,
  input  logic [NRD*AW-1:0]   rdsel,
  output logic [NRD*XLEN-1:0] rdout,
  output logic [NRD-1:0]      rdbusy,
  output logic                collide
);

  localparam bit Z = (ZERO_R0 != 0);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic             collide_q, collide_d;

  logic [XLEN-1:0]  src;
  logic [XLEN-1:0]  exec_data;
  logic             sign;
  int               nbits;
  logic             wr_en, ld_en, issue_en;

  // Source select, then keep the low nbits and fill the rest with sign or zero.
  always_comb begin
    case (wrsrc)
      2'd0:    src = din;
      2'd1:    src = retaddr;
      2'd2:    src = imm;
      default: src = aluout;
    endcase
    case (width)
      2'd0:    nbits = 8;
      2'd1:    nbits = 16;
      2'd2:    nbits = 32;
      default: nbits = XLEN;
    endcase
    if (nbits > XLEN) nbits = XLEN;
    sign = sext & src[nbits-1];
    for (int b = 0; b < XLEN; b++) begin
      exec_data[b] = (b < nbits) ? src[b] : sign;
    end
  end

  assign wr_en    = wr    & ~(Z && (wrsel     == '0));
  assign ld_en    = ldwr  & ~(Z && (ldsel     == '0));
  assign issue_en = issue & ~(Z && (issue_sel == '0));

  // Execute write is applied after the load return so it wins a collision;
  // issue is applied after the clear so a new load keeps the register busy.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (ld_en) begin
      regs_d[ldsel] = lddata;
      busy_d[ldsel] = 1'b0;
    end
    if (wr_en)    regs_d[wrsel]     = exec_data;
    if (issue_en) busy_d[issue_sel] = 1'b1;
    collide_d = wr_en & ld_en & (wrsel == ldsel);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
      busy_q    <= '0;
      collide_q <= 1'b0;
    end else begin
      regs_q    <= regs_d;
      busy_q    <= busy_d;
      collide_q <= collide_d;
    end
  end

  assign collide = collide_q;

  generate
    for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0]   sel;
      logic            ld_hit, wr_hit, is_r0;
      assign sel    = rdsel[i*AW +: AW];
      assign ld_hit = ldwr && (ldsel == sel);
      assign wr_hit = wr && (wrsel == sel);
      assign is_r0  = Z && (sel == '0);
      assign rdout[i*XLEN +: XLEN] = is_r0  ? '0 :
                                     wr_hit ? exec_data :
                                     ld_hit ? lddata : regs_q[sel];
      assign rdbusy[i] = ~is_r0 & busy_q[sel] & ~ld_hit;
    end
  endgenerate

endmodule

`default_nettype wire
